// File: rtl/patch_embed_pkg.sv
// Shared types and arithmetic helpers for the streaming patch embedder.
package patch_embed_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int SR_W = 64;

    function automatic int calc_acc_w(input int dw, input int patch_size);
        return 2 * dw + $clog2(patch_size) + 1;
    endfunction

    // Round half-up at the binary point, then clamp to the signed dw-bit range.
    function automatic logic signed [SR_W-1:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                          input int frac_bits,
                                                          input int dw);
        logic signed [SR_W-1:0] r;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        r = acc;
        if (frac_bits > 0)
            r = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi)
            return hi;
        if (r < lo)
            return lo;
        return r;
    endfunction

endpackage

// File: rtl/patch_embed_stream_mac_lane.sv
// One signed fixed-point MAC lane: preload, accumulate, optional late offset add,
// and a rounded/saturated view of the accumulator.
module pe_mac_lane
    import patch_embed_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_W      = 43
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         preload,
    input  logic signed [DATA_WIDTH:0]   preload_val,
    input  logic                         acc_en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic                         add_en,
    input  logic signed [DATA_WIDTH-1:0] add_val,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  pre_ext;
    logic signed [ACC_W-1:0]  add_ext;
    logic signed [ACC_W-1:0]  acc_sum;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign pre_ext  = {{(ACC_W-DATA_WIDTH-1-FRAC_BITS){preload_val[DATA_WIDTH]}},
                       preload_val, {FRAC_BITS{1'b0}}};
    assign add_ext  = add_en ? {{(ACC_W-DATA_WIDTH-FRAC_BITS){add_val[DATA_WIDTH-1]}},
                                add_val, {FRAC_BITS{1'b0}}} : '0;

    // The late offset is visible on the output in the same cycle it is folded in,
    // so the emitted value does not change across that boundary.
    assign acc_sum = acc + add_ext;
    assign result  = DATA_WIDTH'(sat_round({{(SR_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum},
                                           FRAC_BITS, DATA_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (preload)
            acc <= pre_ext;
        else if (acc_en)
            acc <= acc + prod_ext;
        else if (add_en)
            acc <= acc_sum;
    end

endmodule

// File: rtl/patch_embed_stream.sv
// Streaming patch embedder: buffers one patch, projects it with LANES MACs per pass.
// Optional POS_EMBED_EN adds a positional-embedding read port summed with the bias.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_LOAD | accepting PATCH_SIZE pixels into the patch buffer
//   S_MAC  | PATCH_SIZE+1 cycles: bias preload, then one weight per cycle
//   S_EMIT | streaming LANES results of the current dimension group
//   S_DONE | one-cycle done pulse
module patch_embed_stream
    import patch_embed_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IMG_H      = 224,
    parameter int IMG_W      = 224,
    parameter int C          = 3,
    parameter int PH         = 16,
    parameter int PW         = 16,
    parameter int E          = 128,
    parameter int LANES      = 4,
    localparam int PATCH_SIZE  = PH * PW * C,
    localparam int NUM_PATCHES = (IMG_H / PH) * (IMG_W / PW),
    localparam int GROUPS      = E / LANES,
    localparam int AW          = $clog2(PATCH_SIZE * GROUPS),
    localparam int PAT_W       = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1,
    localparam int DIM_W       = $clog2(E)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [DATA_WIDTH-1:0]       pix_data,
    output logic [AW-1:0]               w_addr,
    input  logic [DATA_WIDTH*LANES-1:0] w_rdata,
    input  logic [DATA_WIDTH*E-1:0]     b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [PAT_W-1:0]            out_patch,
    output logic [DIM_W-1:0]            out_dim,
    output logic                        out_last
`ifdef POS_EMBED_EN
    ,
    output logic [$clog2(NUM_PATCHES*GROUPS)-1:0] pos_addr,
    input  logic [DATA_WIDTH*LANES-1:0]           pos_rdata
`endif
);

    localparam int ACC_W = calc_acc_w(DATA_WIDTH, PATCH_SIZE);
    localparam int PXW   = $clog2(PATCH_SIZE + 1);
    localparam int BW    = $clog2(PATCH_SIZE);
    localparam int GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [PXW-1:0]   PX_LAST    = PXW'(PATCH_SIZE - 1);
    localparam logic [PXW-1:0]   PX_END     = PXW'(PATCH_SIZE);
    localparam logic [GW-1:0]    GRP_LAST   = GW'(GROUPS - 1);
    localparam logic [LW-1:0]    LANE_LAST  = LW'(LANES - 1);
    localparam logic [PAT_W-1:0] PATCH_LAST = PAT_W'(NUM_PATCHES - 1);
    localparam logic [DIM_W-1:0] DIM_LAST   = DIM_W'(E - 1);

    state_t                       state;
    logic [PXW-1:0]               px;
    logic [BW-1:0]                px_d;
    logic [GW-1:0]                grp;
    logic [LW-1:0]                lane;
    logic [PAT_W-1:0]             patch;
    logic [DIM_W-1:0]             dim;
    logic signed [DATA_WIDTH-1:0] pix_buf [PATCH_SIZE];
    logic signed [DATA_WIDTH-1:0] lane_res [LANES];
    logic                         lane_preload;
    logic                         lane_acc_en;
    logic                         lane_add_en;

    always_ff @(posedge clk) begin
        if (state == S_LOAD && pix_valid)
            pix_buf[px[BW-1:0]] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            px        <= '0;
            px_d      <= '0;
            grp       <= '0;
            lane      <= '0;
            patch     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        patch     <= '0;
                        px        <= '0;
                        grp       <= '0;
                        lane      <= '0;
                        pix_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        px <= px + 1'b1;
                        if (px == PX_LAST) begin
                            state     <= S_MAC;
                            px        <= '0;
                            grp       <= '0;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                S_MAC: begin
                    // px_d trails the issued address by the weight memory latency.
                    px_d <= px[BW-1:0];
                    px   <= px + 1'b1;
                    if (px == PX_END) begin
                        state <= S_EMIT;
                        px    <= '0;
                        lane  <= '0;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (lane == LANE_LAST) begin
                            lane <= '0;
                            if (grp != GRP_LAST) begin
                                grp   <= grp + 1'b1;
                                state <= S_MAC;
                            end else if (patch != PATCH_LAST) begin
                                patch     <= patch + 1'b1;
                                px        <= '0;
                                state     <= S_LOAD;
                                pix_ready <= 1'b1;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lane_preload = (state == S_MAC) && (px == '0);
    assign lane_acc_en  = (state == S_MAC) && (px != '0);
    assign w_addr       = AW'(32'(px) * GROUPS + 32'(grp));

    assign dim       = DIM_W'(32'(grp) * LANES + 32'(lane));
    assign out_valid = (state == S_EMIT);
    assign out_data  = out_valid ? lane_res[lane] : '0;
    assign out_patch = out_valid ? patch : '0;
    assign out_dim   = out_valid ? dim : '0;
    assign out_last  = out_valid && (patch == PATCH_LAST) && (dim == DIM_LAST);

`ifdef POS_EMBED_EN
    localparam int POS_AW = $clog2(NUM_PATCHES * GROUPS);
    logic pos_first;

    // pos_rdata lands in the first emit cycle; lanes fold it in there.
    assign pos_addr    = POS_AW'(32'(patch) * GROUPS + 32'(grp));
    assign lane_add_en = pos_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos_first <= 1'b0;
        else
            pos_first <= (state == S_MAC) && (px == PX_END);
    end
`else
    assign lane_add_en = 1'b0;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] bias_k;
        logic signed [DATA_WIDTH-1:0] add_k;
        logic signed [DATA_WIDTH:0]   pre_val;

        assign bias_k  = b_in[(32'(grp) * LANES + k) * DATA_WIDTH +: DATA_WIDTH];
        assign pre_val = {bias_k[DATA_WIDTH-1], bias_k};
`ifdef POS_EMBED_EN
        assign add_k = pos_rdata[k*DATA_WIDTH +: DATA_WIDTH];
`else
        assign add_k = '0;
`endif

        pe_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .ACC_W     (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .preload    (lane_preload),
            .preload_val(pre_val),
            .acc_en     (lane_acc_en),
            .a          (pix_buf[px_d]),
            .b          (w_rdata[k*DATA_WIDTH +: DATA_WIDTH]),
            .add_en     (lane_add_en),
            .add_val    (add_k),
            .result     (lane_res[k])
        );
    end

endmodule

// File: tb/tb_patch_embed_stream.sv
// Bench for patch_embed_stream on a 4x4 single-channel image, 2x2 patches, E=4, LANES=2.
module tb_patch_embed_stream;

    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int IMG_H = 4;
    localparam int IMG_W = 4;
    localparam int C     = 1;
    localparam int PH    = 2;
    localparam int PW    = 2;
    localparam int E     = 4;
    localparam int LANES = 2;
    localparam int PS    = PH * PW * C;
    localparam int NP    = (IMG_H / PH) * (IMG_W / PW);
    localparam int G     = E / LANES;
    localparam int AW    = $clog2(PS * G);
    localparam int PAT_W = $clog2(NP);
    localparam int DIM_W = $clog2(E);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                pix_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [DW-1:0]       pix_data = '0;
    logic                busy, done, pix_ready, out_valid, out_last;
    logic [DW-1:0]       out_data;
    logic [AW-1:0]       w_addr;
    logic [DW*LANES-1:0] w_rdata;
    logic [DW*E-1:0]     b_in;
    logic [PAT_W-1:0]    out_patch;
    logic [DIM_W-1:0]    out_dim;

    logic [DW-1:0]       pix_img [NP*PS];
    logic [DW*LANES-1:0] wmem [PS*G];
    logic [DW-1:0]       bias_v [E];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) w_rdata <= wmem[w_addr];

    always_comb begin
        b_in = '0;
        for (int d = 0; d < E; d++)
            b_in[d*DW +: DW] = bias_v[d];
    end

`ifdef POS_EMBED_EN
    localparam int PAW = $clog2(NP * G);
    logic [PAW-1:0]      pos_addr;
    logic [DW*LANES-1:0] pos_rdata;
    logic [DW*LANES-1:0] pos_mem [NP*G];
    always @(posedge clk) pos_rdata <= pos_mem[pos_addr];
`endif

    patch_embed_stream #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .IMG_H(IMG_H), .IMG_W(IMG_W), .C(C),
        .PH(PH), .PW(PW), .E(E), .LANES(LANES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data (pix_data),
        .w_addr   (w_addr),
        .w_rdata  (w_rdata),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_patch(out_patch),
        .out_dim  (out_dim),
        .out_last (out_last)
`ifdef POS_EMBED_EN
        ,
        .pos_addr (pos_addr),
        .pos_rdata(pos_rdata)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision dot product of the patch with weight column d,
    // plus (bias [+ pos]) scaled to the accumulator's binary point.
    function automatic logic [DW-1:0] model(input int p, input int d);
        longint acc;
        longint base;
        longint hi;
        longint lo;
        int g;
        int k;
        logic [DW*LANES-1:0] word;
        logic [DW-1:0] wv;
        g = d / LANES;
        k = d % LANES;
        base = longint'($signed(bias_v[d]));
`ifdef POS_EMBED_EN
        word = pos_mem[p*G+g];
        wv = word[k*DW +: DW];
        base += longint'($signed(wv));
`endif
        acc = base * (longint'(1) << FB);
        for (int i = 0; i < PS; i++) begin
            word = wmem[i*G+g];
            wv = word[k*DW +: DW];
            acc += longint'($signed(pix_img[p*PS+i])) * longint'($signed(wv));
        end
        acc = (acc + (longint'(1) << (FB - 1))) >>> FB;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        return DW'(acc);
    endfunction

    task automatic check_reset_values(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_pix_ready"}, pix_ready, 0);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_out_last"}, out_last, 0);
        check_val({tag, "_out_data"}, out_data, 0);
        check_val({tag, "_out_patch"}, out_patch, 0);
        check_val({tag, "_out_dim"}, out_dim, 0);
        check_val({tag, "_w_addr"}, w_addr, 0);
    endtask

    task automatic fill_const(input logic [DW-1:0] pv, input logic [DW-1:0] wv, input bit zero_bias);
        for (int i = 0; i < NP*PS; i++) pix_img[i] = pv;
        for (int j = 0; j < PS*G; j++) wmem[j] = {LANES{wv}};
        if (zero_bias)
            for (int d = 0; d < E; d++) bias_v[d] = '0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP*PS; i++) pix_img[i] = DW'($urandom_range(0, 1023) - 512);
        for (int j = 0; j < PS*G; j++)
            for (int k = 0; k < LANES; k++)
                wmem[j][k*DW +: DW] = DW'($urandom_range(0, 1023) - 512);
        for (int d = 0; d < E; d++) bias_v[d] = DW'($urandom_range(0, 8191) - 4096);
    endtask

    // One image; rnd adds pixel gaps and consumer backpressure, abort stops early
    // in the first MAC cycle of patch 1 so the caller can pull reset.
    task automatic run_image(input bit rnd, input bit mid_start, input bit abort);
        int pidx = 0;
        int oidx = 0;
        int cyc = 0;
        int final_cyc = -1;
        int abort_cnt = 0;
        bit stalled = 1'b0;
        bit done_seen = 1'b0;
        logic [DW-1:0] held = '0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            start = (cyc == 0) || (mid_start && cyc == 40);
            if (cyc == 1) check_val("busy_after_start", busy, 1);
            if (pidx < NP*PS && (!rnd || $urandom_range(0, 3) != 0)) begin
                pix_valid = 1'b1;
                pix_data  = pix_img[pidx];
            end else begin
                pix_valid = 1'b0;
                pix_data  = DW'($urandom);
            end
            if (pix_valid && pix_ready) pidx++;
            if (abort && pidx == 2*PS) begin
                abort_cnt++;
                if (abort_cnt == 2) break;
            end
            if (stalled) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, held);
            end
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                check_val("output_in_range", oidx < NP*E, 1);
                if (oidx < NP*E) begin
                    check_val("data", out_data, model(oidx / E, oidx % E));
                    check_val("patch", out_patch, oidx / E);
                    check_val("dim", out_dim, oidx % E);
                    check_val("last", out_last, oidx == NP*E - 1);
                end
                oidx++;
                if (oidx == NP*E) final_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) begin
                done_seen = 1'b1;
                check_val("done_timing", cyc, final_cyc + 1);
                check_val("outputs_count", oidx, NP*E);
                check_val("pixels_used", pidx, NP*PS);
            end
            cyc++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        out_ready = 1'b0;
        if (!abort) begin
            check_val("done_seen", done_seen, 1);
            @(negedge clk);
            check_val("done_cleared", done, 0);
            check_val("busy_cleared", busy, 0);
        end
    endtask

    initial begin
`ifdef POS_EMBED_EN
        for (int p = 0; p < NP; p++)
            for (int g = 0; g < G; g++)
                for (int k = 0; k < LANES; k++)
                    pos_mem[p*G+g][k*DW +: DW] = DW'(p * 256);
`endif
        fill_const('0, '0, 1'b1);
        repeat (2) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        fill_const(16'h0100, 16'h0080, 1'b1);
        run_image(1'b0, 1'b0, 1'b0);

        fill_const(16'h7FFF, 16'h7FFF, 1'b1);
        run_image(1'b0, 1'b0, 1'b0);

        fill_const(16'h7FFF, 16'h8000, 1'b1);
        run_image(1'b0, 1'b0, 1'b0);

        fill_random();
        for (int i = 0; i < NP*PS; i++) pix_img[i] = '0;
        for (int d = 0; d < E; d++) bias_v[d] = DW'(d * 256);
        run_image(1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_image(1'b1, 1'b1, 1'b0);
        end

        fill_random();
        run_image(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        run_image(1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/patch_embed_stream.md
Name: patch_embed_stream

Overview:
- Streaming, parameterised successor to the flat-bus patch embedder: pixels arrive patch by patch over a valid/ready stream.
- Each patch is buffered locally, then projected to E dimensions by LANES parallel signed fixed-point MACs. Weights come from an external synchronous-read memory.
- Results leave as an element stream with patch/dim tags.
- Sits between the image DMA/reformatter and the transformer encoder input FIFO.

Parameters:
- DATA_WIDTH, 16, signed Qm.FRAC_BITS width of pixels, weights, bias, outputs
- FRAC_BITS, 8, fractional bits of every operand and of the output
- IMG_H, 224, image height
- IMG_W, 224, image width
- C, 3, channels
- PH, 16, patch height
- PW, 16, patch width
- E, 128, embedding dim; must be a multiple of LANES
- LANES, 4, parallel MAC lanes = output dims computed per pass

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one image (NUM_PATCHES patches); ignored while busy
- busy  out  1  high from the start-accept cycle through the done cycle
- done  out  1  one-cycle pulse after the last output handshake
- pix_valid  in  1  pixel stream valid
- pix_ready  out  1  high only in S_LOAD
- pix_data  in  DATA_WIDTH  pixel; per patch in (ly, lx, ch) order, patches row-major
- w_addr  out  clog2(PATCH_SIZE*E/LANES)  weight address = px*(E/LANES)+grp
- w_rdata  in  DATA_WIDTH*LANES  lane k at bits [k*DW +: DW]; data valid the cycle after w_addr
- b_in  in  DATA_WIDTH*E  bias, static while busy
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_WIDTH  saturated result
- out_patch  out  clog2(NUM_PATCHES)  patch index
- out_dim  out  clog2(E)  dimension index
- out_last  out  1  high on the final element of the image

Behaviour:
- Derived values: PATCH_SIZE=PH*PW*C; NUM_PATCHES=(IMG_H/PH)*(IMG_W/PW); ACC_W=2*DATA_WIDTH+clog2(PATCH_SIZE)+1.
- Reset: state S_IDLE; all counters 0; busy, done, pix_ready, out_valid, out_last = 0; out_data, out_patch, out_dim = 0; w_addr = 0.
- S_IDLE: start=1 -> S_LOAD, with patch=0 and busy=1 from the next cycle.
- S_LOAD: each pix_valid&pix_ready handshake writes buf[px] and increments px. The handshake on px=PATCH_SIZE-1 -> S_MAC with grp=0, px=0.
- S_MAC:
  - Cycle 0 issues w_addr for px=0; one address is issued per cycle. Accumulate uses a one-cycle pipeline: acc[k] += buf[px_d]*w_rdata[k], with px_d the 1-cycle-delayed px.
  - acc[k] is preloaded with sext(b_in[grp*LANES+k]) <<< FRAC_BITS.
  - Exactly PATCH_SIZE+1 cycles, then -> S_EMIT.
- S_EMIT:
  - Lane k result = sat(round(acc[k])). round adds 1<<(FRAC_BITS-1) and then arithmetic-shifts right by FRAC_BITS. sat clamps to [-2^(DW-1), 2^(DW-1)-1].
  - Elements are emitted k=0..LANES-1 with out_dim=grp*LANES+k.
  - out_valid holds, and data stays stable, until out_ready; the next element appears the cycle after a handshake.
  - After lane LANES-1 handshakes:
    - grp<E/LANES-1 -> grp++, S_MAC (buffer reused).
    - Else if patch<NUM_PATCHES-1 -> patch++, px=0, S_LOAD.
    - Else -> S_DONE.
- S_DONE: done=1 for one cycle; busy=0 from the next cycle -> S_IDLE.
- out_last = 1 only for patch=NUM_PATCHES-1 and dim=E-1.
- start during busy is ignored. pix_valid outside S_LOAD is not consumed. out_ready while out_valid=0 has no effect.
- Throughput per patch: PATCH_SIZE load + (E/LANES)*(PATCH_SIZE+1+LANES) cycles, with no backpressure.
- rst_n asserted mid-operation aborts immediately to reset values; a partial patch is discarded.

Optional Feature:
- POS_EMBED_EN: adds ports pos_addr (out, clog2(NUM_PATCHES*E/LANES)) and pos_rdata (in, DATA_WIDTH*LANES, 1-cycle latency).
  - pos_addr = patch*(E/LANES)+grp is issued in the last S_MAC cycle.
  - The preload becomes sext(bias + pos) <<< FRAC_BITS, with the sum taken in DATA_WIDTH+1 bits.
- Without the macro: no pos ports exist and results are bias-only.

Decomposition:
- patch_embed_pkg: state_t enum (S_IDLE, S_LOAD, S_MAC, S_EMIT, S_DONE), plus functions sat_round(acc, FRAC_BITS, DW) and calc_acc_w.
- Sub-module pe_mac_lane: one signed MAC with clear/preload, accumulate enable, and rounding/saturating output; instantiated LANES times.

Test Plan:
- IMG 4x4, C=1, PH=PW=2, E=4, LANES=2. All pixels 1.0 (0x0100), all weights 0.5 (0x0080), bias 0 -> 16 outputs each 0x0200; out_last only on patch 3 dim 3; done one cycle after that handshake.
- Same config, weights 0x7FFF, pixels 0x7FFF -> every output saturates to 0x7FFF. Weights 0x8000, pixels 0x7FFF -> every output saturates to 0x8000.
- Bias ramp b[d]=d*0x0100, zero pixels -> out_data=d*0x0100 matching out_dim 0..3 for every patch.
- Random out_ready (50%) and pix_valid gaps -> outputs match the golden model, and out_data stays stable while out_valid&&!out_ready.
- Assert start mid-image -> ignored. Assert rst_n low during S_MAC of patch 1 -> all outputs at reset values. A fresh start afterwards produces a correct full image.
- With POS_EMBED_EN, pos[p][d]=p*0x0100, bias 0, zero pixels -> out_data = out_patch*0x0100.
